// File: rtl/first_cpu_pkg.sv
// Shared constants and types for the first_cpu pipeline: fetch, instruction
// memory and decoder all agree on these widths and on the reset PC.
package first_cpu_pkg;

  localparam int unsigned ADDR_W     = 3;
  localparam int unsigned INST_W     = 8;
  localparam int unsigned RESET_PC   = 0;
  localparam int unsigned MEM_DEPTH  = 2 ** ADDR_W;
  localparam int unsigned PERF_CNT_W = 16;

  typedef logic [ADDR_W-1:0]     addr_t;
  typedef logic [INST_W-1:0]     inst_t;
  typedef logic [PERF_CNT_W-1:0] perf_cnt_t;

  // Sequential successor of a fetch address; wraps at the top of memory.
  function automatic addr_t addr_next(input addr_t a);
    return a + addr_t'(1);
  endfunction

endpackage

// File: rtl/fetch_perf_counter.sv
// Saturating event counter used for the retired-instruction statistic.
// Sticks at all-ones instead of wrapping so overflow is never misread.
module fetch_perf_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;
  logic             w_sat;

  assign w_sat   = &r_count;
  assign o_count = r_count;

  // Count events with synchronous clear; hold once saturated.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_inc && !w_sat) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, addresses the 1-cycle-latency instruction memory
// and hands {instruction, pc} to the decoder over valid/ready.
// Optional feature macro: FETCH_PERF_CNT_EN (retired-instruction counter).
// Without it retired_count is tied to zero and no counter flops exist.
module inst_fetch #(
  parameter int unsigned ADDR_W   = first_cpu_pkg::ADDR_W,
  parameter int unsigned INST_W   = first_cpu_pkg::INST_W,
  parameter int unsigned RESET_PC = first_cpu_pkg::RESET_PC
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                run,
  input  logic                                jump_en,
  input  logic [ADDR_W-1:0]                   jump_target,
  output logic [ADDR_W-1:0]                   mem_addr,
  input  logic [INST_W-1:0]                   mem_inst,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [INST_W-1:0]                   out_inst,
  output logic [ADDR_W-1:0]                   out_pc,
  output logic [first_cpu_pkg::PERF_CNT_W-1:0] retired_count
);

  import first_cpu_pkg::*;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_out_pc;
  logic              r_out_valid;
  logic              w_advance;
  logic              w_accept;

  // The presented slot can be replaced when it is empty or being taken.
  assign w_advance = out_ready | ~r_out_valid;
  assign w_accept  = r_out_valid & out_ready;

  // On a stall the memory re-reads the presented address, so mem_inst stays
  // stable without a skid buffer.
  assign mem_addr  = w_advance ? r_pc : r_out_pc;

  assign out_inst  = mem_inst;
  assign out_pc    = r_out_pc;
  assign out_valid = r_out_valid;

  // PC / presented-slot update: reset, then redirect, then advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= ADDR_W'(RESET_PC);
      r_out_pc    <= '0;
      r_out_valid <= 1'b0;
    end else if (jump_en) begin
      // The fetch already in flight is wrong-path; drop it.
      r_pc        <= jump_target;
      r_out_valid <= 1'b0;
    end else if (w_advance) begin
      if (run) begin
        r_out_pc    <= r_pc;
        r_out_valid <= 1'b1;
        r_pc        <= r_pc + ADDR_W'(1);
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_counter #(
    .WIDTH (PERF_CNT_W)
  ) u_perf_counter (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_inc   (w_accept),
    .o_count (retired_count)
  );
`else
  logic w_unused_accept;
  assign w_unused_accept = w_accept;
  assign retired_count   = '0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a behavioural 1-cycle-latency memory.
module tb_inst_fetch;

  logic       clk;
  logic       rst;
  logic       run;
  logic       jump_en;
  logic [2:0] jump_target;
  logic [2:0] mem_addr;
  logic [7:0] mem_inst;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_inst;
  logic [2:0] out_pc;
  logic [15:0] retired_count;

  logic [7:0] mem [8];
  int         n_tests;
  int         n_fail;
  int         acc;     // model of accepted instructions
  logic       exp_v;   // model of current out_valid

  inst_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .jump_en       (jump_en),
    .jump_target   (jump_target),
    .mem_addr      (mem_addr),
    .mem_inst      (mem_inst),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .retired_count (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_inst <= mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; count an acceptance if the model says one happens.
  task automatic step();
    if (exp_v && out_ready && !rst) acc++;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_inst(input string tag, input logic [2:0] pc);
    exp_v = 1'b1;
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".pc"}, {29'd0, out_pc}, {29'd0, pc});
    check({tag, ".inst"}, {24'd0, out_inst}, {24'd0, mem[pc]});
  endtask

  task automatic expect_bubble(input string tag);
    exp_v = 1'b0;
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef FETCH_PERF_CNT_EN
    return acc;
`else
    return 32'd0;
`endif
  endfunction

  initial begin
    logic [7:0] init [8];
    init = '{8'h00, 8'h55, 8'hAA, 8'hFF, 8'h0F, 8'h5A, 8'hA5, 8'hF0};
    for (int i = 0; i < 8; i++) mem[i] = init[i];
    n_tests = 0; n_fail = 0; acc = 0; exp_v = 1'b0;
    rst = 1'b1; run = 1'b0; jump_en = 1'b0; jump_target = '0; out_ready = 1'b1;

    step(); step();
    expect_bubble("reset");
    check("reset.pc", {29'd0, out_pc}, 32'd0);
    check("reset.cnt", {16'd0, retired_count}, 32'd0);
    check("reset.addr", {29'd0, mem_addr}, 32'd0);

    // Streaming with wrap
    rst = 1'b0; run = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      expect_inst($sformatf("stream%0d", i), 3'(i));
    end

    // Stall while pc=2 is presented
    step(); expect_inst("pre1", 3'd1);
    step(); expect_inst("pre2", 3'd2);
    out_ready = 1'b0;
    #1;
    check("stall.addr0", {29'd0, mem_addr}, 32'd2);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_inst($sformatf("stall%0d", i), 3'd2);
      check($sformatf("stall%0d.addr", i), {29'd0, mem_addr}, 32'd2);
    end
    out_ready = 1'b1;
    step(); expect_inst("release", 3'd3);

    // Jump to 6 while pc=3 is presented and accepted
    jump_en = 1'b1; jump_target = 3'd6;
    step(); expect_bubble("jump.bubble");
    jump_en = 1'b0;
    step(); expect_inst("jump.tgt", 3'd6);
    step(); expect_inst("jump.next", 3'd7);
    step(); expect_inst("jump.wrap", 3'd0);

    // Jump during stall, target 1
    out_ready = 1'b0; jump_en = 1'b1; jump_target = 3'd1;
    step(); expect_bubble("sjump.bubble");
    jump_en = 1'b0; out_ready = 1'b1;
    step(); expect_inst("sjump.tgt", 3'd1);
    step(); expect_inst("sjump.p2", 3'd2);
    step(); expect_inst("sjump.p3", 3'd3);
    step(); expect_inst("sjump.p4", 3'd4);

    // Halt after pc=4 issued
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); expect_bubble($sformatf("halt%0d", i));
    end
    check("halt.addr", {29'd0, mem_addr}, 32'd5);
    run = 1'b1;
    step(); expect_inst("resume", 3'd5);

    // run falls while stalled: held instruction survives until taken
    out_ready = 1'b0; run = 1'b0;
    step(); expect_inst("runfall.hold", 3'd5);
    out_ready = 1'b1;
    step(); expect_bubble("runfall.drop");
    check("cnt.mid", {16'd0, retired_count}, exp_cnt());

    // Reset mid-stream
    run = 1'b1;
    step(); expect_inst("prerst", 3'd6);
    rst = 1'b1;
    step(); expect_bubble("rst.mid");
    acc = 0;
    check("rst.cnt", {16'd0, retired_count}, 32'd0);
    check("rst.addr", {29'd0, mem_addr}, 32'd0);
    rst = 1'b0;
    step(); expect_inst("rst.first", 3'd0);
    step(); expect_inst("rst.second", 3'd1);
    check("cnt.end", {16'd0, retired_count}, exp_cnt());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
